// File: rtl/timer_sched_pkg.sv
// Shared types and defaults for the timer scheduler block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package timer_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RELEASE = 2'd2
    } sched_state_t;

    localparam int NUM_REQ_DEF = 3;

endpackage : timer_sched_pkg

// File: rtl/rr_pick.sv
// Round-robin priority picker: first set request strictly after ptr, wrapping.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   req      request vector
//   ptr      index of the last winner; search starts at ptr+1
//   gnt_oh   one-hot winner (zero if no request)
//   gnt_idx  winner index (valid only when vld)
//   vld      at least one request present
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt_oh,
    output logic [PTR_W-1:0]   gnt_idx,
    output logic               vld
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0] idx;

    // Walk the candidates in priority order ptr+1, ptr+2, ... ptr; the
    // last one visited is ptr itself, so the previous owner ranks lowest.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        vld     = 1'b0;
        idx     = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (idx == LAST) ? '0 : idx + 1'b1;
            if (!vld && req[idx]) begin
                vld         = 1'b1;
                gnt_oh[idx] = 1'b1;
                gnt_idx     = idx;
            end
        end
    end

endmodule : rr_pick

// File: rtl/timer.sv
// Fixed-duration cycle timer: done asserts after DURATION enabled edges.
// Latency: done is combinational from the count; count clears one edge after enable drops.
// Backpressure: none; the count saturates at DURATION while enable stays high.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   enable      count while high, clear while low
//   done        count has reached DURATION
module timer #(
    parameter int DURATION = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic done
);

    localparam int CNT_W = $clog2(DURATION + 1);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DURATION);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!enable) begin
            cnt_d = '0;
        end else if (cnt_q != TERM) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == TERM);

endmodule : timer

// File: rtl/timer_scheduler.sv
// Round-robin sharing of one fixed-duration timer among NUM_REQ requesters.
// Latency: grant 1 edge after request in IDLE; expire pulse DURATION+1 edges after grant, grant drops 1 edge later.
// Backpressure: non-owner requests wait (as live levels) until IDLE; no queueing.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   req_i       level requests, held until the matching expire/abort pulse
//   grant_o     one-hot (or zero) current timer owner
//   expire_o    one-cycle pulse: owner's timeout elapsed
//   abort_o     one-cycle pulse: owner dropped its request before expiry
//   busy_o      timer in use (state is not IDLE)
module timer_scheduler
    import timer_sched_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int DURATION = 100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [NUM_REQ-1:0] expire_o,
    output logic [NUM_REQ-1:0] abort_o,
    output logic               busy_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    sched_state_t       state_q,  state_d;
    logic [NUM_REQ-1:0] grant_q,  grant_d;
    logic [NUM_REQ-1:0] expire_q, expire_d;
    logic [NUM_REQ-1:0] abort_q,  abort_d;
    logic [PTR_W-1:0]   ptr_q,    ptr_d;

    logic [NUM_REQ-1:0] pick_oh;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_vld;
    logic               tmr_en;
    logic               tmr_done;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req     (req_i),
        .ptr     (ptr_q),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx),
        .vld     (pick_vld)
    );

    // Timer runs only in RUN; the single low cycle in RELEASE clears it so
    // every grant times a full DURATION.
    assign tmr_en = (state_q == RUN);

    timer #(
        .DURATION (DURATION)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (tmr_en),
        .done   (tmr_done)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        expire_d = '0;
        abort_d  = '0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_oh;
                    ptr_d   = pick_idx;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Expiry takes precedence over a same-cycle request drop.
                if (tmr_done) begin
                    expire_d = grant_q;
                    state_d  = RELEASE;
                end else if ((req_i & grant_q) == '0) begin
                    abort_d = grant_q;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            expire_q <= '0;
            abort_q  <= '0;
            ptr_q    <= PTR_W'(NUM_REQ - 1);
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            expire_q <= expire_d;
            abort_q  <= abort_d;
            ptr_q    <= ptr_d;
        end
    end

    assign grant_o  = grant_q;
    assign expire_o = expire_q;
    assign abort_o  = abort_q;
    assign busy_o   = (state_q != IDLE);

endmodule : timer_scheduler

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler with NUM_REQ=3, DURATION=4.
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected values are hand-derived from the grant/expire timing.
module tb_timer_scheduler;

    localparam int N   = 3;
    localparam int DUR = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req_i;
    logic [N-1:0] grant_o;
    logic [N-1:0] expire_o;
    logic [N-1:0] abort_o;
    logic         busy_o;

    int total;
    int bad;

    timer_scheduler #(
        .NUM_REQ  (N),
        .DURATION (DUR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req_i),
        .grant_o  (grant_o),
        .expire_o (expire_o),
        .abort_o  (abort_o),
        .busy_o   (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // One active edge, then land on the falling edge for drive/sample.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_grant"},  grant_o,  '0);
        chk({tag, "_expire"}, expire_o, '0);
        chk({tag, "_abort"},  abort_o,  '0);
        chk({tag, "_busy"},   busy_o,   '0);
    endtask

    // Called just after the grant edge E0. Checks quiet through E0+DUR,
    // then the expire pulse after E0+DUR+1. drop_at_done lowers the
    // owner's request while done is being sampled.
    task automatic run_to_expire(input string tag, input logic [N-1:0] g,
                                 input bit drop_at_done);
        chk({tag, "_grant"}, grant_o, g);
        chk({tag, "_busy"},  busy_o,  1);
        repeat (DUR) begin
            step();
            chk({tag, "_quiet"}, expire_o | abort_o, '0);
        end
        if (drop_at_done) req_i = req_i & ~g;
        step();
        chk({tag, "_expire"},   expire_o, g);
        chk({tag, "_noabort"},  abort_o,  '0);
        chk({tag, "_grantrel"}, grant_o,  g);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // 1: reset with all requests high
        rst_n = 1'b0;
        req_i = 3'b111;
        #12;
        chk_idle("rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("first_grant", grant_o, 3'b001);

        // 3: all requesting, each drops after its expire; grants 7 apart
        run_to_expire("rr0", 3'b001, 1'b0);
        req_i = 3'b110;
        step();
        chk_idle("rr0_idle");
        step();
        run_to_expire("rr1", 3'b010, 1'b0);
        req_i = 3'b100;
        step();
        step();
        run_to_expire("rr2", 3'b100, 1'b0);
        req_i = 3'b000;
        step();
        chk_idle("rr2_idle");

        // 2: single requester; expire exactly one cycle at E0+5
        req_i = 3'b010;
        step();
        run_to_expire("single", 3'b010, 1'b0);
        req_i = 3'b000;
        step();
        chk_idle("single_idle");

        // 4: drop two cycles after grant -> abort, then full re-time
        req_i = 3'b001;
        step();
        chk("ab_grant", grant_o, 3'b001);
        step();
        step();
        req_i = 3'b000;
        step();
        chk("ab_abort",    abort_o,  3'b001);
        chk("ab_noexpire", expire_o, '0);
        step();
        chk_idle("ab_idle");
        req_i = 3'b001;
        step();
        run_to_expire("ab_retry", 3'b001, 1'b0);
        req_i = 3'b000;
        step();
        chk_idle("ab_retry_idle");

        // 5: request drops in the cycle done is sampled -> expire wins
        req_i = 3'b100;
        step();
        run_to_expire("tie", 3'b100, 1'b1);
        step();
        chk_idle("tie_idle");

        // Fairness: owner keeps requesting past its expire, loses to req 1
        req_i = 3'b011;
        step();
        run_to_expire("fair0", 3'b001, 1'b0);
        step();
        step();
        chk("fair_next", grant_o, 3'b010);
        run_to_expire("fair1", 3'b010, 1'b0);
        req_i = 3'b001;
        step();
        step();
        chk("fair_back", grant_o, 3'b001);
        req_i = 3'b000;
        step();
        chk("fair_abort", abort_o, 3'b001);
        step();
        chk_idle("fair_idle");

        // 6: reset pulse mid-RUN, then a full-duration re-grant
        req_i = 3'b010;
        step();
        chk("mr_grant", grant_o, 3'b010);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk_idle("mr_async");
        step();
        chk_idle("mr_held");
        rst_n = 1'b1;
        step();
        run_to_expire("mr_after", 3'b010, 1'b0);
        req_i = 3'b000;
        step();
        chk_idle("mr_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_timer_scheduler
